// File: rtl/score_tracker.sv
// score_tracker: run/game-over FSM that accumulates the score on frame ticks and commits the high score after a game-over delay.
module score_tracker #(
  parameter int FRAME_PER_POINT = 6,
  parameter int HI_DELAY_FRAMES = 60,
  parameter int SCORE_MAX       = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        hit,
  output logic [31:0] score,
  output logic [31:0] score_hi,
  output logic        running,
  output logic        game_over,
  output logic        hi_update
);
  localparam int FW = $clog2(FRAME_PER_POINT + 1);
  localparam int DW = $clog2(HI_DELAY_FRAMES + 1);
  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;
  state_t          state;
  logic [FW-1:0]   frame_cnt;
  logic [DW-1:0]   delay_cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      score     <= '0;
      score_hi  <= '0;
      frame_cnt <= '0;
      delay_cnt <= '0;
      running   <= 1'b0;
      game_over <= 1'b0;
      hi_update <= 1'b0;
    end else begin
      hi_update <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state     <= RUN;
          score     <= '0;
          frame_cnt <= '0;
          running   <= 1'b1;
        end
        RUN: if (hit) begin
          state     <= OVER;
          running   <= 1'b0;
          game_over <= 1'b1;
          delay_cnt <= '0;
        end else if (frame_tick) begin
          frame_cnt <= (frame_cnt == FW'(FRAME_PER_POINT - 1)) ? '0 : frame_cnt + 1'b1;
          if (frame_cnt == FW'(FRAME_PER_POINT - 1) && score < 32'(SCORE_MAX))
            score <= score + 32'd1;
        end
        OVER: if (frame_tick) begin
          delay_cnt <= delay_cnt + 1'b1;
          // the tick that completes the delay returns to IDLE and commits a strictly better score
          if (delay_cnt == DW'(HI_DELAY_FRAMES - 1)) begin
            state     <= IDLE;
            game_over <= 1'b0;
            if (score > score_hi) begin
              score_hi  <= score;
              hi_update <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
